// File: rtl/dac_ser_pkg.sv
// Shared types for the DAC frame serializer: sample width, FSM states and
// the stereo sample pair stored in the FIFO and shifted onto the pin.
package dac_ser_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } ser_state_t;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stereo_sample_t;

endpackage

// File: rtl/dac_frame_serializer_if.sv
// Sample input bundle of the DAC frame serializer.
interface dac_frame_serializer_if;
    import dac_ser_pkg::*;

    // A sample moves on a clk edge where s_valid && s_ready; the source may
    // change s_left/s_right freely while s_valid is low.
    logic                s_valid;
    logic                s_ready;
    logic [SAMPLE_W-1:0] s_left;
    logic [SAMPLE_W-1:0] s_right;

    modport master (output s_valid, output s_left, output s_right, input s_ready);
    modport slave  (input s_valid, input s_left, input s_right, output s_ready);

endinterface

// File: rtl/sync_sample_fifo.sv
// Single-clock FIFO of stereo sample pairs with a registered occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_sample_fifo
    import dac_ser_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push_i,
    input  stereo_sample_t push_data_i,
    input  logic           pop_i,
    output stereo_sample_t head_o,
    output logic [AW:0]    level_o,
    output logic           full_o,
    output logic           empty_o
);

    stereo_sample_t mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    level_q;
    logic           do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage carries no reset; only the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/dac_frame_serializer.sv
// Buffers stereo samples and serializes them to the codec in DSP mode B,
// generating BCLK/DACLRC/DACDAT from clk. Option: DAC_UNDERRUN_HOLD_EN.
module dac_frame_serializer
    import dac_ser_pkg::*;
#(
    parameter int BCLK_DIV    = 8,
    parameter int FRAME_BCLKS = 64,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    dac_frame_serializer_if.slave         s_if,
    output logic                          bclk,
    output logic                          dac_lrck,
    output logic                          dac_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output ser_state_t                    dbg_state
);

    localparam int DIV_W   = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W   = $clog2(FRAME_BCLKS);
    localparam int FRAME_W = 2 * SAMPLE_W;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(FRAME_BCLKS - 1);

    ser_state_t          state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;
    logic                bclk_q, bclk_d;
    logic                lrck_q, lrck_d;
    logic                data_q, data_d;
    logic                underrun_q, underrun_d;

    logic                tick, fall, wrap, pop;
    logic                fifo_full, fifo_empty;
    stereo_sample_t      fifo_head, underrun_fill, frame_src;
    logic [FRAME_W-1:0]  frame_bits;

    sync_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (s_if.s_valid && s_if.s_ready),
        .push_data_i ({s_if.s_left, s_if.s_right}),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .level_o     (fifo_level),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign s_if.s_ready = !fifo_full;

`ifdef DAC_UNDERRUN_HOLD_EN
    stereo_sample_t hold_q, hold_d;

    always_comb begin
        hold_d = hold_q;
        if (pop) hold_d = fifo_head;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) hold_q <= '0;
        else        hold_q <= hold_d;
    end

    assign underrun_fill = hold_q;
`else
    assign underrun_fill = '0;
`endif

    assign frame_src  = fifo_empty ? underrun_fill : fifo_head;
    assign frame_bits = frame_src;

    // A fall event is the divider wrap while bclk is high; wrap marks the
    // fall that begins a new frame (bit counter rolling over to 0).
    assign tick = (div_cnt_q == DIV_MAX);
    assign fall = tick && bclk_q;
    assign wrap = fall && (bit_cnt_q == BIT_MAX);

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        bclk_d     = bclk_q;
        lrck_d     = lrck_q;
        data_d     = data_q;
        underrun_d = 1'b0;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                bclk_d    = 1'b0;
                lrck_d    = 1'b0;
                data_d    = 1'b0;
                div_cnt_d = '0;
                bit_cnt_d = BIT_MAX;
                if (enable) state_d = RUN;
            end
            RUN, STOP: begin
                if (state_q == STOP && !enable && wrap) begin
                    state_d   = IDLE;
                    bclk_d    = 1'b0;
                    lrck_d    = 1'b0;
                    data_d    = 1'b0;
                    div_cnt_d = '0;
                    bit_cnt_d = BIT_MAX;
                end else begin
                    state_d   = enable ? RUN : STOP;
                    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
                    if (tick) bclk_d = !bclk_q;
                    if (fall) begin
                        lrck_d = wrap;
                        if (wrap) begin
                            bit_cnt_d  = '0;
                            pop        = !fifo_empty;
                            underrun_d = fifo_empty;
                            data_d     = frame_bits[FRAME_W-1];
                            shift_d    = {frame_bits[FRAME_W-2:0], 1'b0};
                        end else begin
                            // Zero fill shifts in behind the right sample for the pad bits.
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                            data_d    = shift_q[FRAME_W-1];
                            shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= BIT_MAX;
            shift_q    <= '0;
            bclk_q     <= 1'b0;
            lrck_q     <= 1'b0;
            data_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            bclk_q     <= bclk_d;
            lrck_q     <= lrck_d;
            data_q     <= data_d;
            underrun_q <= underrun_d;
        end
    end

    assign bclk      = bclk_q;
    assign dac_lrck  = lrck_q;
    assign dac_data  = data_q;
    assign underrun  = underrun_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dac_frame_serializer.sv
// Bench for dac_frame_serializer: a default instance (8/64) and a minimum
// instance (2/32), both checked every cycle against a timeline model.
module tb_dac_frame_serializer;
    import dac_ser_pkg::*;

    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUTs ----------------
    logic       en_a, en_b;
    logic       bclk_a, lrck_a, data_a, ur_a;
    logic       bclk_b, lrck_b, data_b, ur_b;
    logic [2:0] lvl_a, lvl_b;
    ser_state_t dbg_state_a, dbg_state_b;

    dac_frame_serializer_if if_a ();
    dac_frame_serializer_if if_b ();

    dac_frame_serializer #(.BCLK_DIV(8), .FRAME_BCLKS(64), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk(clk), .reset(reset), .enable(en_a), .s_if(if_a),
        .bclk(bclk_a), .dac_lrck(lrck_a), .dac_data(data_a),
        .fifo_level(lvl_a), .underrun(ur_a), .dbg_state(dbg_state_a)
    );

    dac_frame_serializer #(.BCLK_DIV(2), .FRAME_BCLKS(32), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .reset(reset), .enable(en_b), .s_if(if_b),
        .bclk(bclk_b), .dac_lrck(lrck_b), .dac_data(data_b),
        .fifo_level(lvl_b), .underrun(ur_b), .dbg_state(dbg_state_b)
    );

    // ---------------- reference model ----------------
    // Timeline view: t counts clk edges since the enabling edge; bclk is
    // (t/D)%2, fall k happens at t=2Dk and selects frame bit (k-1)%F.
    int          m_D [2];
    int          m_F [2];
    int          m_t [2];
    bit          m_run [2];
    bit          m_stop [2];
    bit          m_ur [2];
    logic [31:0] m_pair [2];
    logic [31:0] m_q [2][DEPTH];
    int          m_head [2];
    int          m_cnt [2];
`ifdef DAC_UNDERRUN_HOLD_EN
    logic [31:0] m_last [2];
`endif

    task automatic model_reset(int i);
        m_D[i]    = (i == 0) ? 8 : 2;
        m_F[i]    = (i == 0) ? 64 : 32;
        m_t[i]    = 0;
        m_run[i]  = 1'b0;
        m_stop[i] = 1'b0;
        m_ur[i]   = 1'b0;
        m_pair[i] = '0;
        m_head[i] = 0;
        m_cnt[i]  = 0;
`ifdef DAC_UNDERRUN_HOLD_EN
        m_last[i] = '0;
`endif
    endtask

    task automatic model_edge(int i, logic en, logic vld, logic [31:0] din);
        int c0;
        int period;
        c0 = m_cnt[i];
        period = 2 * m_D[i];
        m_ur[i] = 1'b0;
        if (!m_run[i]) begin
            if (en) begin
                m_run[i]  = 1'b1;
                m_t[i]    = 0;
                m_stop[i] = 1'b0;
            end
        end else begin
            m_t[i] = m_t[i] + 1;
            if ((m_t[i] % period) == 0 && (((m_t[i] / period) - 1) % m_F[i]) == 0) begin
                if (m_stop[i] && !en) begin
                    m_run[i] = 1'b0;
                end else if (c0 == 0) begin
                    m_ur[i] = 1'b1;
`ifdef DAC_UNDERRUN_HOLD_EN
                    m_pair[i] = m_last[i];
`else
                    m_pair[i] = '0;
`endif
                end else begin
                    m_pair[i] = m_q[i][m_head[i]];
`ifdef DAC_UNDERRUN_HOLD_EN
                    m_last[i] = m_pair[i];
`endif
                    m_head[i] = (m_head[i] + 1) % DEPTH;
                    m_cnt[i]  = m_cnt[i] - 1;
                end
            end
            if (m_run[i]) m_stop[i] = !en;
        end
        if (vld && c0 < DEPTH) begin
            m_q[i][(m_head[i] + m_cnt[i]) % DEPTH] = din;
            m_cnt[i] = m_cnt[i] + 1;
        end
    endtask

    function automatic logic [7:0] exp_pins(int i);
        logic b, l, d;
        int   k, bit_i;
        b = 1'b0; l = 1'b0; d = 1'b0;
        if (m_run[i]) begin
            b = ((m_t[i] / m_D[i]) % 2) == 1;
            if (m_t[i] >= 2 * m_D[i]) begin
                k     = m_t[i] / (2 * m_D[i]);
                bit_i = (k - 1) % m_F[i];
                l     = (bit_i == 0);
                d     = (bit_i < 32) ? m_pair[i][31 - bit_i] : 1'b0;
            end
        end
        return {b, l, d, m_ur[i], (m_cnt[i] < DEPTH), 3'(m_cnt[i])};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_edge(0, en_a, if_a.s_valid, {if_a.s_left, if_a.s_right});
            model_edge(1, en_b, if_b.s_valid, {if_b.s_left, if_b.s_right});
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks;
    int n_errors;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_a(logic [15:0] l, logic [15:0] r);
        @(negedge clk);
        if_a.s_valid = 1'b1;
        if_a.s_left  = l;
        if_a.s_right = r;
        @(negedge clk);
        if_a.s_valid = 1'b0;
    endtask

    task automatic wait_lrck_a(string name);
        int guard;
        guard = 0;
        while (!lrck_a && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check(name, guard < 3000, 1);
    endtask

    // Records the 64 bits the codec latches on bclk rises of one frame.
    task automatic capture_a(output logic [63:0] frame, output int lr_n,
                             output int ur_n, output int per);
        int   nbits, cyc, first_rise;
        logic prev;
        frame = '0; lr_n = 0; ur_n = 0; per = 0; nbits = 0; cyc = 0; first_rise = -1;
        wait_lrck_a("cap_lrck_timeout");
        prev = bclk_a;
        while (nbits < 64 && cyc < 1100) begin
            if (lrck_a) lr_n++;
            if (ur_a) ur_n++;
            if (bclk_a && !prev) begin
                frame = {frame[62:0], data_a};
                nbits++;
                if (first_rise < 0) first_rise = cyc;
                else if (per == 0) per = cyc - first_rise;
            end
            prev = bclk_a;
            @(negedge clk);
            cyc++;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] frame;
        int          lr_n, ur_n, per, cnt, rises, urs;
        logic        prev;
        int          pa, pb;

        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        en_a = 1'b0; en_b = 1'b0;
        if_a.s_valid = 1'b0; if_a.s_left = '0; if_a.s_right = '0;
        if_b.s_valid = 1'b0; if_b.s_left = '0; if_b.s_right = '0;

        fork
            forever begin
                @(negedge clk);
                check("pins_a", {bclk_a, lrck_a, data_a, ur_a, if_a.s_ready, lvl_a}, exp_pins(0));
                check("pins_b", {bclk_b, lrck_b, data_b, ur_b, if_b.s_ready, lvl_b}, exp_pins(1));
            end
        join_none

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_pins_a", {bclk_a, lrck_a, data_a, ur_a, if_a.s_ready, lvl_a}, 8'h08);
        check("reset_state_a", dbg_state_a, IDLE);

        // Minimum configuration: 32 bclks of 4 clk each, frames back to back.
        en_b = 1'b1;
        cnt = 0;
        while (!lrck_b && cnt < 1000) begin @(negedge clk); cnt++; end
        cnt = 0;
        while (lrck_b && cnt < 1000) begin @(negedge clk); cnt++; end
        while (!lrck_b && cnt < 1000) begin @(negedge clk); cnt++; end
        check("b_frame_len", cnt, 128);

        // Frame layout, then a second pair, then an underrun frame.
        push_a(16'h8001, 16'h7FFE);
        push_a(16'h1234, 16'hABCD);
        en_a = 1'b1;
        capture_a(frame, lr_n, ur_n, per);
        check("t1_frame", frame, 64'h8001_7FFE_0000_0000);
        check("t1_lrck_width", lr_n, 16);
        check("t1_bclk_period", per, 16);
        check("t1_no_underrun", ur_n, 0);
        capture_a(frame, lr_n, ur_n, per);
        check("t3_pair_frame", frame, 64'h1234_ABCD_0000_0000);
        capture_a(frame, lr_n, ur_n, per);
`ifdef DAC_UNDERRUN_HOLD_EN
        check("t3_underrun_frame", frame, 64'h1234_ABCD_0000_0000);
`else
        check("t3_underrun_frame", frame, 64'h0);
`endif
        check("t3_underrun_pulses", ur_n, 1);

        // Drop enable during bit 10: frame runs to bit 63, (64-10)*16 clk.
        wait_lrck_a("t4_lrck_timeout");
        repeat (160) @(negedge clk);
        en_a = 1'b0;
        cnt = 0;
        while (dbg_state_a != IDLE && cnt < 2000) begin @(negedge clk); cnt++; end
        check("t4_stop_len", cnt, 864);
        repeat (50) @(negedge clk);
        check("t4_idle_pins", {bclk_a, lrck_a, data_a}, 3'b000);
        // Enable sampled on the next edge; lrck visible 2*8 edges later.
        en_a = 1'b1;
        cnt = 0;
        while (!lrck_a && cnt < 2000) begin @(negedge clk); cnt++; end
        check("t4_restart_latency", cnt, 17);

        // Async reset during bit 20 with two samples waiting.
        push_a(16'h0F0F, 16'hF0F0);
        if_a.s_valid = 1'b1;
        @(negedge clk);
        if_a.s_valid = 1'b0;
        repeat (316) @(negedge clk);
        check("t5_pre_level", lvl_a, 2);
        #2 reset = 1'b0;
        #1;
        check("t5_async_pins_a", {bclk_a, lrck_a, data_a, ur_a, if_a.s_ready, lvl_a}, 8'h08);
        check("t5_async_pins_b", {bclk_b, lrck_b, data_b, ur_b, if_b.s_ready, lvl_b}, 8'h08);
        en_a = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        en_b = 1'b1;

        // Fill while idle, then stream for 8 frames.
        for (int c = 0; c < 12; c++) begin
            if_a.s_valid = 1'b1;
            if_a.s_left  = 16'($urandom);
            if_a.s_right = 16'($urandom);
            @(negedge clk);
        end
        check("t2_level_full", lvl_a, 4);
        check("t2_ready_low", if_a.s_ready, 0);
        en_a = 1'b1;
        rises = 0; urs = 0; prev = lrck_a;
        for (int c = 0; c < 8 * 1024; c++) begin
            if_a.s_left  = 16'($urandom);
            if_a.s_right = 16'($urandom);
            @(negedge clk);
            if (lrck_a && !prev) rises++;
            if (ur_a) urs++;
            prev = lrck_a;
        end
        if_a.s_valid = 1'b0;
        check("t2_frames", rises, 8);
        check("t2_no_underrun", urs, 0);

        // Random traffic and enable toggling on both instances.
        pa = 1; pb = 8;
        for (int c = 0; c < 25000; c++) begin
            @(negedge clk);
            if ((c % 2000) == 0) begin
                pa = $urandom_range(0, 4);
                pb = $urandom_range(0, 30);
            end
            if_a.s_valid = ($urandom_range(0, 999) < pa);
            if_a.s_left  = 16'($urandom);
            if_a.s_right = 16'($urandom);
            if_b.s_valid = ($urandom_range(0, 999) < pb);
            if_b.s_left  = 16'($urandom);
            if_b.s_right = 16'($urandom);
            if ($urandom_range(0, 3999) == 0) en_a = ~en_a;
            if ($urandom_range(0, 499) == 0) en_b = ~en_b;
        end
        if_a.s_valid = 1'b0;
        if_b.s_valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dac_frame_serializer.md
# dac_frame_serializer

Downstream stage of the FIR filter output. It buffers 16-bit stereo samples in a small FIFO and serializes them to the audio codec DAC in DSP mode B, which matches the codec's 0x0E23 interface setting. It generates BCLK, DACLRC and DACDAT from the 50 MHz system clock, which replaces the ad-hoc BCLK/LR-counter logic in the top level. Samples enter through a valid/ready handshake. Underruns are flagged and filled with a defined value.

## Interface
- BCLK_DIV, default 8: clk cycles per BCLK half-period. Must be ≥2. 50 MHz / 16 = 3.125 MHz BCLK.
- FRAME_BCLKS, default 64: BCLK periods per frame. Must be ≥32. Gives a 48.83 kHz frame rate.
- FIFO_DEPTH, default 4: stereo-sample entries. Power of 2, ≥2.

Ports:
- clk, in, 1: system clock, 50 MHz.
- reset, in, 1: asynchronous, active-low reset.
- enable, in, 1: start/stop serializing. Driven by the codec-config-done signal (read_enable).
- s_valid, in, 1: sample offered.
- s_ready, out, 1: FIFO not full.
- s_left, in, 16: signed left sample, two's complement.
- s_right, in, 16: signed right sample.
- bclk, out, 1: codec bit clock.
- dac_lrck, out, 1: frame sync pulse, one BCLK wide.
- dac_data, out, 1: serial data, MSB first.
- fifo_level, out, $clog2(FIFO_DEPTH)+1: current occupancy.
- underrun, out, 1: one-clk pulse when a frame starts with the FIFO empty.

## Operation
- **Handshake**
  - A transfer occurs on a clk edge when s_valid && s_ready.
  - s_ready = (fifo_level < FIFO_DEPTH), combinational from registered level.
  - A push and a pop in the same cycle when full is legal: the pop frees the slot, but s_ready is still low that cycle, so no push happens. Level is unchanged on simultaneous push+pop when not full and not empty.
- **Divider**
  - div_cnt runs 0..BCLK_DIV-1.
  - At BCLK_DIV-1: bclk toggles and div_cnt returns to 0.
  - Fall event = that cycle with bclk==1.
- **FSM states**
  - IDLE:
    - bclk=0, dac_lrck=0, dac_data=0, div_cnt=0, bit_cnt=FRAME_BCLKS-1.
    - enable=1 → RUN.
  - RUN:
    - Divider runs.
    - On each fall event, bit_cnt ← (bit_cnt+1) mod FRAME_BCLKS.
    - If the new bit_cnt==0 (frame start):
      - Pop the FIFO head into shift register {left,right}, or the underrun value if empty, and pulse underrun.
      - dac_lrck←1, dac_data←new MSB (left[15]).
    - Otherwise: dac_lrck←0, dac_data←next bit.
    - Bits 0–15 carry left, 16–31 carry right, 32..FRAME_BCLKS-1 carry 0.
    - enable=0 → STOP.
  - STOP:
    - Continue as RUN, but make no pop at the next frame start.
    - On the fall event where bit_cnt would wrap to 0: go to IDLE and force outputs low.
    - The current frame always completes. Re-asserting enable in STOP returns to RUN with no glitch.
- **FIFO**
  - Contents survive IDLE.
  - Only reset clears them.
  - Pushes are accepted in every state.
- **Reset**
  - Asynchronous and active-low. Reset values:
    - state=IDLE.
    - bclk, dac_lrck, dac_data, underrun = 0.
    - fifo_level=0.
    - s_ready=1.
  - Reset asserted mid-frame truncates the frame immediately.

## Timing
- All outputs are registered on clk; there is no combinational path from inputs to the codec pins.
- The codec samples on the bclk rising edge. Data and lrck change only on fall events, giving BCLK_DIV clk cycles of setup and hold.
- IDLE→RUN transition: first bclk rise occurs BCLK_DIV clk cycles after the edge where enable is sampled high. The first fall event, and therefore frame 0 start, follows BCLK_DIV clk cycles later.
- Push-to-pin latency:
  - A sample pushed into an empty FIFO at least 1 clk before a frame-start fall event appears in that frame.
  - A sample pushed on the same edge as the fall event goes to the next frame.
- fifo_level updates 1 clk after push/pop.

## Configuration
- DAC_UNDERRUN_HOLD_EN:
  - Defined: an underrun frame repeats the last popped sample pair. After reset, with nothing popped yet, it repeats 0.
  - Undefined: an underrun frame sends 0/0 (silence).
  - The underrun pulse fires in both builds.

## Structure
- Package dac_ser_pkg holds:
  - SAMPLE_W=16.
  - typedef ser_state_t {IDLE, RUN, STOP}.
  - The stereo_sample_t struct {left,right}.
- Sub-module sync_sample_fifo:
  - Parameterised depth, single clk, registered level.
  - Instanced once, holding stereo_sample_t entries.
- Divider, bit counter, shift register and FSM live in dac_frame_serializer.

## Test plan
1. Reset, enable=1, push L=16'h8001 R=16'h7FFE → dac_lrck high for exactly 1 BCLK at frame start; bits 0–15 = 1000_0000_0000_0001, bits 16–31 = 0111_1111_1111_1110, bits 32–63 = 0; bclk period = 16 clk.
2. Keep s_valid=1 with the pins stalled in IDLE → s_ready drops after 4 pushes and fifo_level=4. Then set enable=1 → one pop per 1024 clk; data order preserved over 8 samples.
3. enable=1 with the FIFO empty → underrun pulse each frame, with output 0/0. With DAC_UNDERRUN_HOLD_EN and prior sample 16'h1234/16'hABCD, that pair repeats.
4. Drop enable at bit 10 → the frame completes through bit 63, then bclk/lrck/data stay 0. Re-enable → first frame starts 2*BCLK_DIV clk later.
5. Assert reset at bit 20 → all outputs are 0 on the same cycle (async) and fifo_level=0.
6. BCLK_DIV=2, FRAME_BCLKS=32 → frame = 128 clk, with bit 31 adjacent to the next lrck pulse and no gap.
